// File: rtl/regfile_dump_reader.sv
// Register-file dump engine: walks an index range through a borrowed read port,
// streams {idx, data} beats over valid/ready and accumulates a wrapping checksum.
module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_idx,
  input  logic [ADDR_W-1:0] last_idx,
  input  logic              abort,
  output logic              rd_req,
  input  logic              rd_gnt,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_idx,
  output logic [DATA_W-1:0] out_data,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] checksum
);
  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic [ADDR_W-1:0] out_idx_q, out_idx_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;
  logic              err_q, err_d;
  logic              range_bad;

  assign range_bad = (first_idx > last_idx) || (int'(last_idx) >= NUM_REGS);

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    last_d     = last_q;
    out_idx_d  = out_idx_q;
    out_data_d = out_data_q;
    checksum_d = checksum_q;
    err_d      = err_q;
    // abort wins over everything and freezes checksum/err where they are
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          last_d     = last_idx;
          cur_addr_d = first_idx;
          checksum_d = '0;
          err_d      = range_bad;
          state_d    = range_bad ? DONE : READ;
        end
        READ: if (rd_gnt) begin
          out_data_d = rd_data;
          out_idx_d  = cur_addr_q;
          checksum_d = checksum_q + rd_data;
          state_d    = SEND;
        end
        SEND: if (out_ready) begin
          if (cur_addr_q == last_q) begin
            state_d = DONE;
          end else begin
            cur_addr_d = cur_addr_q + 1'b1;
            state_d    = READ;
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      last_q     <= '0;
      out_idx_q  <= '0;
      out_data_q <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      last_q     <= last_d;
      out_idx_q  <= out_idx_d;
      out_data_q <= out_data_d;
      checksum_q <= checksum_d;
      err_q      <= err_d;
    end
  end

  assign rd_req    = (state_q == READ);
  assign rd_addr   = (state_q == READ) ? cur_addr_q : '0;
  assign out_valid = (state_q == SEND);
  assign out_idx   = out_idx_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign err       = err_q;
  assign checksum  = checksum_q;
endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader; register file modelled as a tb array.
module tb_regfile_dump_reader;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  first_idx = '0, last_idx = '0;
  logic        abort = 1'b0;
  logic        rd_req, rd_gnt = 1'b1;
  logic [4:0]  rd_addr;
  logic [63:0] rd_data;
  logic        out_valid, out_ready = 1'b1;
  logic [4:0]  out_idx;
  logic [63:0] out_data;
  logic        busy, done, err;
  logic [63:0] checksum;

  logic [63:0] rf [32];
  logic [4:0]  bq_idx[$];
  logic [63:0] bq_data[$];
  int checks = 0, errors = 0;
  int unstable, addr_moved, grants, cyc;
  bit rdreq_seen, timeout;

  always #5 clk = ~clk;
  assign rd_data = rf[rd_addr];

  regfile_dump_reader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(64)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .abort(abort), .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx), .out_data(out_data),
    .busy(busy), .done(done), .err(err), .checksum(checksum));

  // Drives one dump at negedges; records beats and stall/address stability statistics.
  // cyc = rising edges after the edge that sampled start, at the point done is seen.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int gnt_hold, input bit tog);
    bit prev_req, prev_hold;
    logic [4:0] prev_addr, prev_idx;
    logic [63:0] prev_data;
    bq_idx.delete(); bq_data.delete();
    unstable = 0; addr_moved = 0; grants = 0; rdreq_seen = 0;
    prev_req = 0; prev_hold = 0; prev_addr = '0; prev_idx = '0; prev_data = '0;
    @(negedge clk);
    start = 1'b1; first_idx = f; last_idx = l;
    @(negedge clk);
    start = 1'b0; cyc = 0;
    forever begin
      rd_gnt    = (cyc >= gnt_hold);
      out_ready = tog ? cyc[0] : 1'b1;
      if (rd_req) rdreq_seen = 1;
      if (rd_req && rd_gnt) grants++;
      if (rd_req && prev_req && rd_addr !== prev_addr) addr_moved++;
      if (out_valid && prev_hold && (out_idx !== prev_idx || out_data !== prev_data)) unstable++;
      if (out_valid && out_ready) begin bq_idx.push_back(out_idx); bq_data.push_back(out_data); end
      if (done || cyc > 3000) break;
      prev_req = rd_req && !rd_gnt; prev_addr = rd_addr;
      prev_hold = out_valid && !out_ready; prev_idx = out_idx; prev_data = out_data;
      @(posedge clk); cyc++;
      @(negedge clk);
    end
    timeout = !done;
    rd_gnt = 1'b1; out_ready = 1'b1;
    checks++;
    if (timeout) begin errors++; $display("FAIL dump_timeout %0d..%0d: no done after %0d cycles", f, l, cyc); end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({rd_req, rd_addr, out_valid, out_idx, busy, done, err} !== '0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {rd_req, rd_addr, out_valid, out_idx, busy, done, err});
    end
    checks++;
    if (out_data !== 64'd0 || checksum !== 64'd0) begin
      errors++; $display("FAIL reset_data: out_data %h checksum %h want 0", out_data, checksum);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_full_range();
    for (int i = 0; i < 32; i++) rf[i] = 64'(i * 3);
    run_dump(5'd0, 5'd31, 0, 0);
    checks++;
    if (bq_idx.size() != 32) begin errors++; $display("FAIL full_beats: got %0d want 32", bq_idx.size()); end
    for (int i = 0; i < bq_idx.size() && i < 32; i++) begin
      checks++;
      if (bq_idx[i] !== 5'(i) || bq_data[i] !== 64'(i * 3)) begin
        errors++; $display("FAIL full_beat%0d: got idx %0d data %0d want idx %0d data %0d", i, bq_idx[i], bq_data[i], i, i * 3);
      end
    end
    checks++;
    if (checksum !== 64'd1488) begin errors++; $display("FAIL full_checksum: got %0d want 1488", checksum); end
    checks++;
    if (cyc != 64) begin errors++; $display("FAIL full_latency: got %0d edges want 64", cyc); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL full_err: got %b want 0", err); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL full_done_pulse: done %b busy %b want 0 0", done, busy); end
  endtask

  task automatic test_single();
    rf[5] = '1;
    run_dump(5'd5, 5'd5, 0, 0);
    checks++;
    if (bq_idx.size() != 1) begin errors++; $display("FAIL single_beats: got %0d want 1", bq_idx.size()); end
    else begin
      checks++;
      if (bq_idx[0] !== 5'd5 || bq_data[0] !== '1) begin
        errors++; $display("FAIL single_beat: got idx %0d data %h want 5 ffffffffffffffff", bq_idx[0], bq_data[0]);
      end
    end
    checks++;
    if (checksum !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL single_checksum: got %h want all ones", checksum); end
    checks++;
    if (cyc != 2) begin errors++; $display("FAIL single_latency: got %0d want 2", cyc); end
  endtask

  task automatic test_wrap();
    rf[2] = 64'h8000_0000_0000_0000; rf[3] = 64'h8000_0000_0000_0000;
    run_dump(5'd2, 5'd3, 0, 0);
    checks++;
    if (bq_idx.size() != 2) begin errors++; $display("FAIL wrap_beats: got %0d want 2", bq_idx.size()); end
    checks++;
    if (checksum !== 64'd0) begin errors++; $display("FAIL wrap_checksum: got %h want 0", checksum); end
  endtask

  task automatic test_invalid();
    run_dump(5'd10, 5'd4, 0, 0);
    checks++;
    if (bq_idx.size() != 0) begin errors++; $display("FAIL inv_beats: got %0d want 0", bq_idx.size()); end
    checks++;
    if (rdreq_seen) begin errors++; $display("FAIL inv_rdreq: got 1 want 0"); end
    checks++;
    if (cyc != 0 || done !== 1'b1 || err !== 1'b1) begin
      errors++; $display("FAIL inv_done_err: cyc %0d done %b err %b want 0 1 1", cyc, done, err);
    end
    checks++;
    if (checksum !== 64'd0) begin errors++; $display("FAIL inv_checksum: got %h want 0", checksum); end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 32; i++) rf[i] = 64'(i * 3);
    run_dump(5'd0, 5'd3, 4, 1);
    checks++;
    if (bq_idx.size() != 4) begin errors++; $display("FAIL stall_beats: got %0d want 4", bq_idx.size()); end
    for (int i = 0; i < bq_idx.size() && i < 4; i++) begin
      checks++;
      if (bq_idx[i] !== 5'(i) || bq_data[i] !== 64'(i * 3)) begin
        errors++; $display("FAIL stall_beat%0d: got idx %0d data %0d want %0d %0d", i, bq_idx[i], bq_data[i], i, i * 3);
      end
    end
    checks++;
    if (unstable != 0) begin errors++; $display("FAIL stall_hold: got %0d changes want 0", unstable); end
    checks++;
    if (addr_moved != 0) begin errors++; $display("FAIL stall_addr: got %0d changes want 0", addr_moved); end
    checks++;
    if (grants != 4) begin errors++; $display("FAIL stall_reads: got %0d reads want 4", grants); end
    checks++;
    if (checksum !== 64'd18 || err !== 1'b0) begin errors++; $display("FAIL stall_checksum: got %0d err %b want 18 0", checksum, err); end
  endtask

  task automatic test_abort();
    int n;
    bit seen_done;
    @(negedge clk);
    start = 1'b1; first_idx = 5'd0; last_idx = 5'd7;
    @(negedge clk);
    start = 1'b0; n = 0;
    while (!(out_valid && out_idx == 5'd2) && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n >= 100) begin errors++; $display("FAIL abort_reach: no beat idx 2 within %0d cycles", n); end
    abort = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    abort = 1'b0; out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort_idle: valid %b busy %b done %b want 0 0 0", out_valid, busy, done);
    end
    checks++;
    if (checksum !== 64'd9) begin errors++; $display("FAIL abort_checksum: got %0d want 9", checksum); end
    seen_done = 0;
    repeat (4) begin @(negedge clk); if (done) seen_done = 1; end
    checks++;
    if (seen_done) begin errors++; $display("FAIL abort_no_done: got done pulse want none"); end
    run_dump(5'd0, 5'd7, 0, 0);
    checks++;
    if (bq_idx.size() != 8 || checksum !== 64'd84) begin
      errors++; $display("FAIL abort_redump: got %0d beats checksum %0d want 8 84", bq_idx.size(), checksum);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    start = 1'b1; first_idx = 5'd0; last_idx = 5'd31;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_req, rd_addr, out_valid, out_idx, busy, done, err} !== '0 || out_data !== 64'd0 || checksum !== 64'd0) begin
      errors++; $display("FAIL reset_mid: ctrl %b data %h sum %h want 0", {rd_req, rd_addr, out_valid, out_idx, busy, done, err}, out_data, checksum);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = '0;
    test_reset();
    test_full_range();
    test_single();
    test_wrap();
    test_invalid();
    test_stall();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
